div_unsigned_seq: RTL and testbench
===================================

DIV_UNSIGNED_SEQ -- requirements
Module: div_unsigned_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits (WIDTH >= 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request to begin a division.
REQ-005 SHALL have port dividend, input, WIDTH bits: unsigned numerator, sampled when a start is accepted.
REQ-006 SHALL have port divisor, input, WIDTH bits: unsigned denominator, sampled when a start is accepted.
REQ-007 SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-009 SHALL have port quotient, output, WIDTH bits: the floor of dividend divided by divisor.
REQ-010 SHALL have port remainder, output, WIDTH bits: dividend minus quotient times divisor.
REQ-011 SHALL have port div_by_zero, output, 1 bit: flags that the divisor was zero (see REQ-025).

Function
REQ-012 SHALL implement a restoring, one-quotient-bit-per-cycle division using an FSM with states IDLE, CALC and DONE.
REQ-013 SHALL accept start only when busy=0 (states IDLE or DONE), latching dividend and divisor on that edge.
REQ-014 SHALL ignore start while busy=1; the latched operands are not disturbed.
REQ-015 SHALL use these transitions:
- IDLE -> CALC on an accepted start.
- CALC -> CALC while the iteration counter is below WIDTH-1.
- CALC -> DONE after iteration WIDTH-1.
- DONE -> CALC on an accepted start; otherwise DONE -> IDLE.
REQ-016 SHALL perform the following on each CALC cycle:
- Shift the partial remainder (WIDTH+1 bits) left, bringing in the next dividend bit, MSB first.
- Subtract the divisor if the result is non-negative, writing quotient bit 1; otherwise restore and write 0.
REQ-017 SHALL hold busy=1 for exactly WIDTH cycles after an accept at edge k, and assert done=1 with busy=0 in the cycle after edge k+WIDTH.
REQ-018 SHALL update quotient and remainder only at the edge entering DONE, and hold them stable until the next result.
REQ-019 SHALL produce results that satisfy dividend = quotient*divisor + remainder, with remainder < divisor, for every divisor != 0.
REQ-020 SHALL, when a start is accepted in the DONE cycle, pulse done for that single cycle only and then start the new division (back-to-back operation).
REQ-021 SHALL compute a correct result when dividend < divisor: quotient = 0, remainder = dividend.

Reset
REQ-022 SHALL, while rst_n=0, immediately force:
- state = IDLE, counter = 0;
- busy = 0, done = 0, div_by_zero = 0;
- quotient = 0, remainder = 0.
REQ-023 SHALL abort any division in progress on reset assertion; no done pulse is produced for the aborted division.
REQ-024 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-025 SHALL support the macro DIV_UNSIGNED_SEQ_ZERO_CHK_EN, with this behaviour when defined:
- An accepted start with divisor = 0 goes straight to DONE (done one cycle after the accept, busy never asserted).
- quotient = all ones, remainder = dividend, div_by_zero = 1.
- div_by_zero is cleared on the next accepted start with a nonzero divisor.
REQ-026 SHALL behave as follows when DIV_UNSIGNED_SEQ_ZERO_CHK_EN is undefined:
- div_by_zero is tied to 0.
- A divisor of 0 runs the full WIDTH-cycle sequence and naturally yields quotient = all ones and remainder = dividend.

Verification (WIDTH=8)
REQ-027 SHALL cover: dividend=200, divisor=7, start at edge k -> busy for 8 cycles, done in the cycle after edge k+8, quotient=28, remainder=4.
REQ-028 SHALL cover: 255/1, then 5/9 issued back-to-back (start held high during the done cycle) -> results 255 r0, then 0 r5, each with a single done pulse.
REQ-029 SHALL cover: 100/0 -> with the macro defined: done 1 cycle after accept, quotient=255, remainder=100, div_by_zero=1; without it: done after 8 busy cycles, same quotient/remainder, div_by_zero=0.
REQ-030 SHALL cover: start 50/3, pulse start with 9/9 during cycle 3 of busy -> second request ignored, result quotient=16, remainder=2.
REQ-031 SHALL cover: rst_n low during cycle 4 of busy -> all outputs 0 immediately, no done pulse; 13/4 issued after release -> quotient=3, remainder=1.
REQ-032 SHALL cover: 1000 random operand pairs checked against a reference model -> quotient, remainder and done timing all match.

Source files
------------

// File: rtl/div_unsigned_seq_if.sv
// Handshake and data bundle for the sequential unsigned divider.
// The master side issues start with operands; the slave side returns status and results.
interface div_unsigned_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_unsigned_seq.sv
// Restoring unsigned divider, one quotient bit per clock (IDLE -> CALC x WIDTH -> DONE).
// Optional macro DIV_UNSIGNED_SEQ_ZERO_CHK_EN: zero divisor short-circuits to DONE and raises div_by_zero.
module div_unsigned_seq #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  div_unsigned_seq_if.slave   bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;

  logic [WIDTH:0]   shifted_next;
  logic [WIDTH-1:0] diff_next;
  logic             fits_next;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // One restoring step: the shifted remainder needs WIDTH+1 bits, but the
  // kept remainder always fits in WIDTH bits since it is below the divisor.
  always_comb begin
    shifted_next = {rem_reg, dvd_reg[WIDTH-1]};
    fits_next    = (shifted_next >= {1'b0, dvs_reg});
    diff_next    = shifted_next[WIDTH-1:0] - dvs_reg;
    rem_next     = fits_next ? diff_next : shifted_next[WIDTH-1:0];
    quo_next     = {quo_reg[WIDTH-2:0], fits_next};
  end

`ifdef DIV_UNSIGNED_SEQ_ZERO_CHK_EN
  logic dbz_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      dvd_reg       <= '0;
      dvs_reg       <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
`ifdef DIV_UNSIGNED_SEQ_ZERO_CHK_EN
      dbz_reg       <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (bus.start) begin
            dvd_reg <= bus.dividend;
            dvs_reg <= bus.divisor;
            rem_reg <= '0;
            quo_reg <= '0;
            cnt_reg <= '0;
`ifdef DIV_UNSIGNED_SEQ_ZERO_CHK_EN
            if (bus.divisor == '0) begin
              state_reg     <= DONE;
              done_reg      <= 1'b1;
              quotient_reg  <= '1;
              remainder_reg <= bus.dividend;
              dbz_reg       <= 1'b1;
            end else begin
              state_reg <= CALC;
              busy_reg  <= 1'b1;
              dbz_reg   <= 1'b0;
            end
`else
            state_reg <= CALC;
            busy_reg  <= 1'b1;
`endif
          end else begin
            state_reg <= IDLE;
          end
        end
        CALC: begin
          rem_reg <= rem_next;
          quo_reg <= quo_next;
          dvd_reg <= dvd_reg << 1;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            state_reg     <= DONE;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
            quotient_reg  <= quo_next;
            remainder_reg <= rem_next;
            cnt_reg       <= '0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.quotient  = quotient_reg;
  assign bus.remainder = remainder_reg;
`ifdef DIV_UNSIGNED_SEQ_ZERO_CHK_EN
  assign bus.div_by_zero = dbz_reg;
`else
  assign bus.div_by_zero = 1'b0;
`endif
endmodule

// File: tb/tb_div_unsigned_seq.sv
// Directed and randomized checks of div_unsigned_seq at WIDTH=8: latency, results,
// back-to-back starts, ignored starts while busy, reset abort, zero divisor.
module tb_div_unsigned_seq;
  localparam int W = 8;
`ifdef DIV_UNSIGNED_SEQ_ZERO_CHK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  div_unsigned_seq_if #(.WIDTH(W)) bus ();

  div_unsigned_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
  endtask

  // Called right after the accepting edge has been scheduled; follows the
  // division to its done cycle and checks latency, busy length and results.
  task automatic wait_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] eq, input logic [W-1:0] er,
                             input int glitch, input bit chain,
                             input logic [W-1:0] na, input logic [W-1:0] nb);
    int n;
    int busy_cnt;
    int eb;
    bit edbz;
    eb   = (ZCHK && b == 0) ? 0 : W;
    edbz = ZCHK && (b == 0);
    @(negedge clk);
    bus.start = 1'b0;
    if (eb != 0) check({tag, "_pulse"}, bus.done, 1'b0);
    n = 1;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && n <= 4 * W) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (n == glitch) begin
        bus.start    = 1'b1;
        bus.dividend = 8'd9;
        bus.divisor  = 8'd9;
      end else if (glitch != 0 && n == glitch + 1) begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, bus.done, 1'b1);
    check({tag, "_lat"}, n, eb + 1);
    check({tag, "_busycyc"}, busy_cnt, eb);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_q"}, bus.quotient, eq);
    check({tag, "_r"}, bus.remainder, er);
    check({tag, "_dbz"}, bus.div_by_zero, edbz);
    $display("%s: %0d / %0d -> q=%0d r=%0d dbz=%0b lat=%0d", tag, a, b,
             bus.quotient, bus.remainder, bus.div_by_zero, n);
    if (chain) begin
      bus.start    = 1'b1;
      bus.dividend = na;
      bus.divisor  = nb;
    end else begin
      @(negedge clk);
      check({tag, "_done_off"}, bus.done, 1'b0);
    end
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst_n        = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_q", bus.quotient, 8'd0);
    check("rst_r", bus.remainder, 8'd0);
    check("rst_dbz", bus.div_by_zero, 1'b0);

    // Start presented together with reset release: accepted on the first edge.
    rst_n        = 1'b1;
    bus.start    = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 8'd7;
    wait_result("d200_7", 8'd200, 8'd7, 8'd28, 8'd4, 0, 1'b0, 8'd0, 8'd0);

    issue(8'd255, 8'd1);
    wait_result("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 0, 1'b1, 8'd5, 8'd9);
    wait_result("d5_9", 8'd5, 8'd9, 8'd0, 8'd5, 0, 1'b0, 8'd0, 8'd0);

    issue(8'd100, 8'd0);
    wait_result("d100_0", 8'd100, 8'd0, 8'd255, 8'd100, 0, 1'b0, 8'd0, 8'd0);

    issue(8'd50, 8'd3);
    wait_result("d50_3", 8'd50, 8'd3, 8'd16, 8'd2, 3, 1'b0, 8'd0, 8'd0);

    // Reset in busy cycle 4 aborts the division without a done pulse.
    issue(8'd200, 8'd7);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_q", bus.quotient, 8'd0);
    check("abort_r", bus.remainder, 8'd0);
    check("abort_dbz", bus.div_by_zero, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check("abort_hold_done", bus.done, 1'b0);
      check("abort_hold_busy", bus.busy, 1'b0);
    end
    $display("abort: reset asserted during busy cycle 4");
    rst_n        = 1'b1;
    bus.start    = 1'b1;
    bus.dividend = 8'd13;
    bus.divisor  = 8'd4;
    wait_result("d13_4", 8'd13, 8'd4, 8'd3, 8'd1, 0, 1'b0, 8'd0, 8'd0);

    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom_range(0, 255));
      b = (i % 97 == 0) ? 8'd0 : W'($urandom_range(1, 255));
      issue(a, b);
      if (b == 0)
        wait_result($sformatf("rnd%0d", i), a, b, 8'hFF, a, 0, 1'b0, 8'd0, 8'd0);
      else
        wait_result($sformatf("rnd%0d", i), a, b, a / b, a % b, 0, 1'b0, 8'd0, 8'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
